// File: rtl/mux_sel_sequencer.sv
// Context sequencer: replays a small programmable table of mux selects,
// one entry per enabled cycle, for a programmed number of passes.
module mux_sel_sequencer #(
    parameter int SEL_WIDTH  = 5,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = 4,
    parameter int ITER_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_we,
    input  logic [ADDR_WIDTH-1:0] cfg_addr,
    input  logic [SEL_WIDTH-1:0]  cfg_data,
    input  logic [ADDR_WIDTH:0]   cfg_len,
    input  logic [ITER_WIDTH-1:0] cfg_iter,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  en,
    output logic [SEL_WIDTH-1:0]  s,
    output logic                  s_valid,
    output logic [ADDR_WIDTH-1:0] ctx_idx,
    output logic                  busy,
    output logic                  done,
    output logic                  cfg_err
);

    // Handshake: there is no backpressure; s is meaningful only in cycles
    // where s_valid=1, and s_valid(t+1) mirrors en(t) while running.

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    localparam logic [ADDR_WIDTH:0]   LEN_ONE  = 1;
    localparam logic [ADDR_WIDTH:0]   LEN_MAX  = DEPTH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;
    localparam logic [ITER_WIDTH-1:0] ITER_ONE = 1;

    logic [SEL_WIDTH-1:0] ctx_tbl [DEPTH];

    state_t                state, state_n;
    logic [ADDR_WIDTH-1:0] idx, idx_n, idx_nxt;
    logic [SEL_WIDTH-1:0]  s_q, s_n;
    logic                  sv_q, sv_n;
    logic                  done_q, done_n;
    logic                  err_q, err_n;
    logic [ITER_WIDTH-1:0] cnt, cnt_n;
    logic [ADDR_WIDTH:0]   len_q, len_n;
    logic [ITER_WIDTH-1:0] iter_q, iter_n;
    logic                  last, final_pass, len_ok;

    assign last       = ({1'b0, idx} == (len_q - LEN_ONE));
    assign idx_nxt    = last ? '0 : idx + ADDR_ONE;
    assign final_pass = (iter_q != '0) && (cnt == (iter_q - ITER_ONE));
    assign len_ok     = (cfg_len != '0) && (cfg_len <= LEN_MAX);

    always_comb begin
        state_n = state;
        idx_n   = idx;
        s_n     = s_q;
        sv_n    = 1'b0;
        done_n  = 1'b0;
        err_n   = 1'b0;
        cnt_n   = cnt;
        len_n   = len_q;
        iter_n  = iter_q;
        case (state)
            IDLE: begin
                if (start && !stop && len_ok) begin
                    state_n = RUN;
                    idx_n   = '0;
                    s_n     = ctx_tbl[0];
                    sv_n    = en;
                    cnt_n   = '0;
                    len_n   = cfg_len;
                    iter_n  = cfg_iter;
                end
            end
            RUN: begin
                err_n = cfg_we;
                if (stop) begin
                    state_n = IDLE;
                end else if (en) begin
                    if (last && final_pass) begin
                        state_n = IDLE;
                        done_n  = 1'b1;
                    end else begin
                        idx_n = idx_nxt;
                        s_n   = ctx_tbl[idx_nxt];
                        sv_n  = 1'b1;
                        // Free-running mode saturates rather than wrapping.
                        if (last && (cnt != '1))
                            cnt_n = cnt + ITER_ONE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            idx    <= '0;
            s_q    <= '0;
            sv_q   <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
            cnt    <= '0;
            len_q  <= '0;
            iter_q <= '0;
        end else begin
            state  <= state_n;
            idx    <= idx_n;
            s_q    <= s_n;
            sv_q   <= sv_n;
            done_q <= done_n;
            err_q  <= err_n;
            cnt    <= cnt_n;
            len_q  <= len_n;
            iter_q <= iter_n;
        end
    end

    // Table survives reset; writes are accepted only while idle.
    always_ff @(posedge clk) begin
        if (!rst && (state == IDLE) && cfg_we)
            ctx_tbl[cfg_addr] <= cfg_data;
    end

    assign s       = s_q;
    assign s_valid = sv_q;
    assign ctx_idx = idx;
    assign busy    = (state == RUN);
    assign done    = done_q;
    assign cfg_err = err_q;

endmodule

// File: doc/mux_sel_sequencer.md
Name: mux_sel_sequencer

Overview:
Context sequencer that drives the 5-bit select of a 32:1 PE input multiplexer from a small programmable context table.
- Host loads up to DEPTH select values, then starts the sequencer.
- The sequencer replays the table cyclically for a programmed number of iterations, one entry per enabled cycle.
- It sits between the CGRA configuration bus and each routing mux, so the interconnect can be time-multiplexed without host involvement.

Parameters:
SEL_WIDTH, 5, width of mux select output (32 inputs)
DEPTH, 16, number of context entries
ADDR_WIDTH, 4, log2(DEPTH)
ITER_WIDTH, 16, width of iteration count

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
cfg_we  input  1  write strobe for context table
cfg_addr  input  ADDR_WIDTH  context table write address
cfg_data  input  SEL_WIDTH  select value to store
cfg_len  input  ADDR_WIDTH+1  active entries, legal 1..DEPTH, sampled at start
cfg_iter  input  ITER_WIDTH  passes through table, 0 = run until stop, sampled at start
start  input  1  begin sequencing (pulse)
stop  input  1  abort sequencing (pulse)
en  input  1  advance enable; 0 stalls the sequence
s  output  SEL_WIDTH  registered mux select
s_valid  output  1  s is a live context value this cycle
ctx_idx  output  ADDR_WIDTH  index of entry currently on s
busy  output  1  high in RUN state
done  output  1  one-cycle pulse on normal completion
cfg_err  output  1  one-cycle pulse when cfg_we is rejected

Behaviour:
- Reset (rst=1 at clock edge): state=IDLE; s=0, s_valid=0, ctx_idx=0, busy=0, done=0, cfg_err=0; iteration counter=0.
  - Context table contents are NOT cleared.
  - rst mid-RUN aborts immediately with no done pulse.
- Context table: DEPTH x SEL_WIDTH register array.
  - In IDLE, cfg_we=1 writes cfg_data to entry cfg_addr at the edge.
  - cfg_we in RUN: write is dropped; cfg_err=1 for the next cycle.
  - cfg_len and cfg_iter are latched at start; later changes are ignored until the next start.
- States: IDLE, RUN.
- IDLE -> RUN: start=1, stop=0, 1<=cfg_len<=DEPTH.
  - Next cycle: s=table[0], ctx_idx=0, s_valid=en, busy=1. Latency from start to first select is 1 cycle.
  - start with cfg_len=0 or cfg_len>DEPTH is ignored: stay IDLE, no error pulse.
  - start and stop together in IDLE: stop wins, stay IDLE.
- RUN, each edge with en=1:
  - idx <= (idx==len-1) ? 0 : idx+1; s <= table[next idx].
  - On wrap, iteration counter increments.
- Completion (cfg_iter != 0): on the edge that would wrap while iteration counter == cfg_iter-1:
  - Go to IDLE; done=1 for one cycle.
  - Same edge: s_valid=0, busy=0, s holds its last value.
- cfg_iter = 0: runs until stop, never asserts done; counter saturates at all-ones.
- RUN, en=0: idx, s and counter hold; s_valid=0 that cycle. s_valid follows en registered, i.e. s_valid(t+1) = en(t) while in RUN.
- RUN, stop=1: go to IDLE next edge regardless of en; s_valid=0, busy=0, no done. stop overrides a simultaneous completion, so done is suppressed.
- start in RUN: ignored, no restart.
- len=1: s is constant table[0], and one iteration completes per enabled cycle.
- s holds its last value in IDLE; downstream must qualify s with s_valid.

Test Plan:
1. Reset then idle: rst=1 for 2 cycles -> s=0, s_valid=0, busy=0, done=0; cfg_we writes table[0..3]={7,31,0,12} -> no cfg_err.
2. Basic run: cfg_len=4, cfg_iter=2, start, en=1 -> s sequence 7,31,0,12,7,31,0,12 on 8 consecutive cycles starting 1 cycle after start, ctx_idx 0..3 twice; done=1 exactly on the cycle after the last 12, busy=0 from then.
3. Stall: same setup, en=0 for 3 cycles while s=31 -> s held at 31, s_valid=0 for those 3 cycles; sequence resumes with 0 when en=1; total 8 valid cycles; done still fires once.
4. Abort and illegal config: cfg_iter=0, start, stop after 5 cycles -> busy drops the next cycle, no done. cfg_we during RUN -> table unchanged (re-run shows old data), cfg_err pulses once. start with cfg_len=0 -> remains IDLE.
5. Boundaries: cfg_len=16 with table[15]=5 -> idx wraps 15->0 with s=5 then table[0]. cfg_len=1, cfg_iter=3 -> s=table[0] valid 3 cycles, then done.
6. Reset mid-run: rst asserted during RUN at idx=2 -> next cycle all outputs at reset values, no done. Restart after reset replays the retained table from entry 0.
